// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, samples rows once per
// column slot, debounces press and release, and reports one key at a time.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] key_code,
    output logic       pressed,
    output logic       key_strobe
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE);

    localparam logic [1:0] SCAN        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] slot;
    logic [DW-1:0] deb_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    cand_row;
    logic [1:0]    low_row;
    logic          tick;
    logic          cand_low;

    // The column index is frozen outside SCAN, so it doubles as the candidate column.
    assign col      = ~(4'b0001 << col_idx);
    assign tick     = (slot == SLOT_LAST);
    assign cand_low = ~row[cand_row];

    // Lowest-numbered low row wins when several rows are pulled down.
    always_comb begin
        low_row = 2'd3;
        if (!row[2]) low_row = 2'd2;
        if (!row[1]) low_row = 2'd1;
        if (!row[0]) low_row = 2'd0;
    end

    function automatic logic [7:0] key_map(input logic [1:0] r, input logic [1:0] c);
        key_map = 8'hFF;
        case ({r, c})
            4'h0: key_map = 8'h01;
            4'h1: key_map = 8'h02;
            4'h2: key_map = 8'h03;
            4'h3: key_map = 8'hF0;
            4'h4: key_map = 8'h04;
            4'h5: key_map = 8'h05;
            4'h6: key_map = 8'h06;
            4'h7: key_map = 8'hF1;
            4'h8: key_map = 8'h07;
            4'h9: key_map = 8'h08;
            4'hA: key_map = 8'h09;
            4'hB: key_map = 8'hF2;
            4'hC: key_map = 8'hC0;
            4'hD: key_map = 8'h00;
            4'hE: key_map = 8'hE0;
            4'hF: key_map = 8'hF3;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCAN;
            slot       <= '0;
            deb_cnt    <= '0;
            col_idx    <= 2'd0;
            cand_row   <= 2'd0;
            key_code   <= 8'hFF;
            pressed    <= 1'b0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            slot       <= tick ? '0 : slot + 1'b1;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row == 4'hF) begin
                            col_idx <= col_idx + 1'b1;
                        end else begin
                            cand_row <= low_row;
                            if (DEBOUNCE == 1) begin
                                state      <= HELD;
                                pressed    <= 1'b1;
                                key_code   <= key_map(low_row, col_idx);
                                key_strobe <= 1'b1;
                            end else begin
                                state   <= DEB_PRESS;
                                deb_cnt <= DW'(1);
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (cand_low) begin
                            if (deb_cnt + 1'b1 == DEB_LAST) begin
                                state      <= HELD;
                                pressed    <= 1'b1;
                                key_code   <= key_map(cand_row, col_idx);
                                key_strobe <= 1'b1;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!cand_low) begin
                            if (DEBOUNCE == 1) begin
                                state   <= SCAN;
                                pressed <= 1'b0;
                                col_idx <= col_idx + 1'b1;
                            end else begin
                                state   <= DEB_RELEASE;
                                deb_cnt <= DW'(1);
                            end
                        end
                    end
                    DEB_RELEASE: begin
                        // A low sample means the release was bounce; keep the key held silently.
                        if (!cand_low) begin
                            if (deb_cnt + 1'b1 == DEB_LAST) begin
                                state   <= SCAN;
                                pressed <= 1'b0;
                                col_idx <= col_idx + 1'b1;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix feeds the rows from the
// driven column, and a tick-level press/release model predicts every output.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row = 4'hF;
    logic [3:0] col;
    logic [7:0] key_code;
    logic       pressed;
    logic       key_strobe;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .pressed(pressed),
        .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_strobes = 0;

    logic [15:0] keys = '0;
    logic [7:0]  code_tab [16] = '{8'h01, 8'h02, 8'h03, 8'hF0,
                                   8'h04, 8'h05, 8'h06, 8'hF1,
                                   8'h07, 8'h08, 8'h09, 8'hF2,
                                   8'hC0, 8'h00, 8'hE0, 8'hF3};
    logic [7:0]  exp_q [$];

    // Reference model: slot position, scanned column, and a streak of agreeing samples.
    int         m_slot, m_col, m_cand_r, m_streak;
    bit         m_busy, m_pressed, m_strobe;
    logic [7:0] m_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] v = '0;
        v[r*4+c] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] rows_for(input logic [3:0] c, input logic [15:0] k);
        logic [3:0] r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (k[i*4+j] && !c[j]) r[i] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_slot = 0; m_col = 0; m_cand_r = 0; m_streak = 0;
        m_busy = 0; m_pressed = 0; m_strobe = 0; m_code = 8'hFF;
    endtask

    task automatic accept();
        m_pressed = 1;
        m_streak  = 0;
        m_code    = code_tab[m_cand_r*4 + m_col];
        m_strobe  = 1;
        exp_q.push_back(m_code);
    endtask

    task automatic model_step();
        bit tick;
        int r;
        tick     = (m_slot == SCAN_DIV - 1);
        m_slot   = tick ? 0 : m_slot + 1;
        m_strobe = 0;
        if (!tick) return;
        if (!m_busy) begin
            if (row == 4'hF) m_col = (m_col + 1) % 4;
            else begin
                r = 0;
                while (row[r]) r++;
                m_cand_r = r;
                m_busy   = 1;
                m_streak = 1;
                if (m_streak >= DEB) accept();
            end
        end else if (!m_pressed) begin
            if (!row[m_cand_r]) begin
                m_streak++;
                if (m_streak >= DEB) accept();
            end else begin
                m_busy = 0;
                m_col  = (m_col + 1) % 4;
            end
        end else begin
            if (row[m_cand_r]) begin
                m_streak++;
                if (m_streak >= DEB) begin
                    m_pressed = 0;
                    m_busy    = 0;
                    m_col     = (m_col + 1) % 4;
                end
            end else m_streak = 0;
        end
    endtask

    // One clock: present rows for the current column, clock, then compare at the falling edge.
    task automatic cycle();
        logic [3:0] exp_col;
        row = rows_for(col, keys);
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        exp_col = ~(4'b0001 << m_col);
        check("col", col, exp_col);
        check("pressed", pressed, m_pressed);
        check("key_code", key_code, m_code);
        check("key_strobe", key_strobe, m_strobe);
        if (key_strobe === 1'b1) begin
            n_strobes++;
            if (exp_q.size() > 0) check("strobe_code", key_code, exp_q.pop_front());
            else check("strobe_unexpected", key_strobe, 0);
        end
    endtask

    task automatic wait_pressed(input bit v, input int budget, input string tag);
        int n = 0;
        while (pressed !== v && n < budget) begin
            cycle();
            n++;
        end
        check(tag, pressed, v);
    endtask

    task automatic align_scan(input int c);
        int n = 0;
        logic [3:0] exp_col;
        while (!(m_col == c && m_slot == 0 && !m_busy) && n < 64) begin
            cycle();
            n++;
        end
        exp_col = ~(4'b0001 << c);
        check("align_col", col, exp_col);
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        check("rst_pressed", pressed, 0);
        check("rst_code", key_code, 8'hFF);
        check("rst_col", col, 4'hE);
        check("rst_strobe", key_strobe, 0);
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, k, dur;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_col", col, 4'hE);
        check("reset_code", key_code, 8'hFF);
        check("reset_pressed", pressed, 0);
        check("reset_strobe", key_strobe, 0);
        rst = 1'b0;

        repeat (64) cycle();
        check("idle_strobes", n_strobes, 0);

        // Key 6 held steadily, then released
        keys = key_bit(1, 2);
        s0 = n_strobes;
        wait_pressed(1, 100, "k6_press");
        check("k6_code", key_code, 8'h06);
        check("k6_col", col, 4'b1011);
        repeat (40) cycle();
        check("k6_strobes", n_strobes - s0, 1);
        check("k6_col_held", col, 4'b1011);
        keys = '0;
        wait_pressed(0, 100, "k6_release");
        check("k6_code_kept", key_code, 8'h06);
        check("k6_resume_col", col, 4'b0111);

        // "=" bounces on press: two low ticks, one high tick, then steady
        repeat (8) cycle();
        align_scan(2);
        keys = key_bit(3, 2);
        s0 = n_strobes;
        repeat (8) cycle();
        check("eq_bounce_pending", pressed, 0);
        keys = '0;
        repeat (4) cycle();
        check("eq_bounce_abort", n_strobes - s0, 0);
        check("eq_bounce_col", col, 4'b0111);
        keys = key_bit(3, 2);
        wait_pressed(1, 100, "eq_press");
        check("eq_code", key_code, 8'hE0);
        check("eq_strobes", n_strobes - s0, 1);
        keys = '0;
        wait_pressed(0, 100, "eq_release");

        // "+" bounces on release, then "C"
        repeat (8) cycle();
        keys = key_bit(0, 3);
        wait_pressed(1, 100, "plus_press");
        check("plus_code", key_code, 8'hF0);
        s0 = n_strobes;
        keys = '0;
        repeat (4) cycle();
        keys = key_bit(0, 3);
        repeat (16) cycle();
        check("plus_bounce_held", pressed, 1);
        check("plus_bounce_strobes", n_strobes - s0, 0);
        check("plus_bounce_col", col, 4'b0111);
        keys = '0;
        wait_pressed(0, 100, "plus_release");
        keys = key_bit(3, 0);
        wait_pressed(1, 100, "c_press");
        check("c_code", key_code, 8'hC0);
        keys = '0;
        wait_pressed(0, 100, "c_release");

        // Two rows low on column 0, then reset while held
        repeat (8) cycle();
        keys = key_bit(1, 0) | key_bit(2, 0);
        wait_pressed(1, 100, "dual_press");
        check("dual_code", key_code, 8'h04);
        repeat (6) cycle();
        reset_mid();
        wait_pressed(1, 100, "post_rst_press");
        check("post_rst_code", key_code, 8'h04);
        keys = '0;
        wait_pressed(0, 100, "post_rst_release");

        // Random key activity of random length
        repeat (60) begin
            k = $urandom_range(0, 3);
            if (k == 0) keys = '0;
            else if (k < 3) keys = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            else keys = key_bit($urandom_range(0, 3), $urandom_range(0, 3))
                      | key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            dur = $urandom_range(1, 6) * SCAN_DIV + $urandom_range(0, 3);
            repeat (dur) cycle();
        end
        keys = '0;
        repeat (40) cycle();
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Producer end of the keypad-code interface consumed by the calculator FSM.
- Scans a 4x4 matrix keypad by driving columns and sampling rows, then debounces press and release.
- Outputs an 8-bit key code plus a level `pressed` signal. The consumer registers the code on the falling edge of `pressed`.
- Code map: digits 8'h00–8'h09; operators 8'hF0–8'hF3; Clear 8'hC0; Equal 8'hE0; no key 8'hFF.

Parameters:
- SCAN_DIV, 1000: clock cycles per column slot (must be ≥ 2).
- DEBOUNCE, 4: consecutive agreeing samples required to accept a press or a release (must be ≥ 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- row  input  4  keypad rows, active-low (pulled up externally).
- col  output  4  column drive, one-hot active-low.
- key_code  output  8  code of the accepted key.
- pressed  output  1  high while the accepted key is held (debounced).
- key_strobe  output  1  one-cycle pulse when a press is accepted.

Behaviour:
- Reset values:
  - col = 4'b1110 (column 0 driven).
  - key_code = 8'hFF; pressed = 0; key_strobe = 0.
  - state = SCAN; slot counter = 0; debounce counter = 0.
- Key map (row r, col c):
  - r0: 1, 2, 3, + → 01, 02, 03, F0.
  - r1: 4, 5, 6, - → 04, 05, 06, F1.
  - r2: 7, 8, 9, * → 07, 08, 09, F2.
  - r3: C, 0, =, / → C0, 00, E0, F3.
- Sample tick:
  - The slot counter counts 0..SCAN_DIV-1.
  - The tick is the cycle where the counter equals SCAN_DIV-1.
  - Rows are evaluated only on ticks, giving SCAN_DIV-1 cycles of settle time.
- SCAN state:
  - On a tick with row == 4'hF: advance col by rotating left (1110→1101→1011→0111→1110).
  - On a tick with any row low:
    - Capture the candidate as the lowest-numbered low row plus the current column. Lower row wins when several rows are low.
    - Set debounce count = 1, freeze col, and go to DEB_PRESS.
  - If DEBOUNCE == 1, go directly to HELD instead.
- DEB_PRESS state:
  - On a tick with the candidate row low: increment the count.
  - When the count reaches DEBOUNCE:
    - Go to HELD and set pressed = 1.
    - Load key_code from the map and pulse key_strobe = 1 for one cycle.
    - All three change on that same clock edge.
  - On a tick with the candidate row high: return to SCAN, advance col, and leave outputs unchanged.
- HELD state:
  - col stays frozen; other rows are ignored (no rollover).
  - On a tick with the candidate row high: set count = 1 and go to DEB_RELEASE.
  - If DEBOUNCE == 1, release immediately instead.
- DEB_RELEASE state (pressed stays 1):
  - A tick with the candidate row high increments the count.
  - When the count reaches DEBOUNCE: pressed = 0, go to SCAN, and advance col.
  - A tick with the candidate row low returns to HELD. No new strobe is issued and key_code is unchanged.
- key_code stability:
  - key_code changes only on entry to HELD.
  - It retains the last key after release, so it is stable across the falling edge of pressed.
  - It returns to 8'hFF only on reset.
- A key that is still held is never re-reported. A new strobe requires a debounced release followed by a fresh press.
- Asynchronous rst during any state aborts immediately to the reset values. A key held through reset deassertion is re-detected as a fresh press after DEBOUNCE ticks.
- Column timing: in SCAN, col changes only on the clock edge following a tick, so each column is driven for exactly SCAN_DIV cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE=3):
- Reset, no keys pressed for 64 cycles:
  - col cycles E→D→B→7→E, changing every 4 cycles.
  - pressed = 0, key_code = FF, key_strobe never asserted.
- Hold row1/col2 (key 6) low steadily:
  - On the third consecutive tick at column 2: pressed rises, key_code = 8'h06, key_strobe is a single 1-cycle pulse.
  - col stays at 4'b1011 while the key is held.
- Release key 6:
  - After 3 high ticks, pressed falls and key_code stays 8'h06.
  - Scanning resumes at col = 4'b0111.
- Bounce on press: key "=" (r3, c2) low for 2 ticks, high for 1 tick, then low:
  - No strobe from the first burst; scanner returns to SCAN.
  - Later acceptance gives key_code = 8'hE0 with exactly one strobe.
- Bounce on release, then second key:
  - Held key "+" (r0, c3) goes high for 1 tick, then low again: pressed stays 1, no extra strobe.
  - After a full release, pressing "C" (r3, c0) gives key_code = 8'hC0.
- Simultaneous keys and reset:
  - Rows 1 and 2 low on column 0 → key_code = 8'h04 (lower row wins).
  - Assert rst mid-HELD → pressed = 0, key_code = FF, col = E immediately.
